// File: rtl/sap1_ram.sv
// SAP-1 16x8 program/data RAM: combinational W-bus read and a debounced manual write in program mode.
// Define SAP1_RAM_PRELOAD_EN to have CLR load the demo program instead of zeros.
module sap1_ram #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] D,
    input  logic              WR_BTN,
    input  logic              PROG,
    input  logic              CE,
    output logic [DATA_W-1:0] W_BUS,
    output logic              WR_BUSY,
    output logic              WR_DONE
);

    localparam int DEPTH = int'(2 ** ADDR_W);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StIdle, StDebounce, StWrite, StRelease} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               b_s1, b_s;
    logic [DATA_W-1:0]  mem_q [DEPTH];

`ifdef SAP1_RAM_PRELOAD_EN
    if (DATA_W != 8 || ADDR_W != 4) begin : g_bad_preload
        $error("SAP1_RAM_PRELOAD_EN requires DATA_W=8 and ADDR_W=4");
    end

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        case (a)
            4'h0:    return DATA_W'(8'h09);
            4'h1:    return DATA_W'(8'h1A);
            4'h2:    return DATA_W'(8'h1B);
            4'h3:    return DATA_W'(8'h2C);
            4'h4:    return DATA_W'(8'hE0);
            4'h5:    return DATA_W'(8'hF0);
            4'h9:    return DATA_W'(8'h01);
            4'hA:    return DATA_W'(8'h02);
            4'hB:    return DATA_W'(8'h03);
            4'hC:    return DATA_W'(8'h04);
            default: return '0;
        endcase
    endfunction
`endif

    // Raw button is asynchronous to CLK; only b_s is used downstream.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            b_s1 <= 1'b0;
            b_s  <= 1'b0;
        end else begin
            b_s1 <= WR_BTN;
            b_s  <= b_s1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (b_s && PROG) begin
                    state_d = StDebounce;
                    cnt_d   = CNT_W'(1);
                end
            end
            StDebounce: begin
                if (!b_s || !PROG) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Commit is already decided here, so PROG is not re-checked.
            StWrite: state_d = StRelease;
            StRelease: begin
                if (!b_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef SAP1_RAM_PRELOAD_EN
                mem_q[i] <= init_word(ADDR_W'(i));
`else
                mem_q[i] <= '0;
`endif
            end
        end else if (state_q == StWrite) begin
            mem_q[ADDR] <= D;
        end
    end

    assign W_BUS   = CE ? mem_q[ADDR] : '0;
    assign WR_BUSY = (state_q != StIdle);
    assign WR_DONE = (state_q == StWrite);

endmodule

// File: tb/tb_sap1_ram.sv
// Scoreboard bench for sap1_ram: stimulus queues expected values, a negedge monitor compares them.
module tb_sap1_ram;

    localparam int N = 4;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] ADDR;
    logic [7:0] D;
    logic       WR_BTN;
    logic       PROG;
    logic       CE;
    logic [7:0] W_BUS;
    logic       WR_BUSY;
    logic       WR_DONE;

    sap1_ram #(
        .DATA_W         (8),
        .ADDR_W         (4),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .ADDR   (ADDR),
        .D      (D),
        .WR_BTN (WR_BTN),
        .PROG   (PROG),
        .CE     (CE),
        .W_BUS  (W_BUS),
        .WR_BUSY(WR_BUSY),
        .WR_DONE(WR_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         sel;  // 0 W_BUS, 1 WR_BUSY, 2 WR_DONE, 3 WR_DONE pulse count
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] act;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [7:0] init_mem [16];

    always @(negedge CLK) begin
        if (WR_DONE === 1'b1) done_cnt++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = W_BUS;
                1:       act = {7'b0, WR_BUSY};
                2:       act = {7'b0, WR_DONE};
                default: act = 8'(done_cnt);
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input int sel, input logic [7:0] exp, input string name);
        exp_t x;
        x.sel  = sel;
        x.exp  = exp;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) init_mem[i] = 8'h00;
`ifdef SAP1_RAM_PRELOAD_EN
        init_mem[0] = 8'h09; init_mem[1] = 8'h1A; init_mem[2] = 8'h1B; init_mem[3] = 8'h2C;
        init_mem[4] = 8'hE0; init_mem[5] = 8'hF0; init_mem[9] = 8'h01; init_mem[10] = 8'h02;
        init_mem[11] = 8'h03; init_mem[12] = 8'h04;
`endif
        CLR = 1'b1; CE = 1'b1; PROG = 1'b0; WR_BTN = 1'b0; D = 8'h00; ADDR = 4'h0;
        tick(2);

        // Reset: sweep all addresses with CLR held
        push(1, 8'h00, "reset_busy");
        push(2, 8'h00, "reset_done");
        for (int a = 0; a < 16; a++) begin
            ADDR = 4'(a);
            push(0, init_mem[a], $sformatf("reset_rd_%0h", a));
            tick();
        end
        CLR = 1'b0;
        tick();

        // Debounced write of A7 at 5; WR_DONE must appear N+3 edges after the press
        PROG = 1'b1; CE = 1'b0; ADDR = 4'h5; D = 8'hA7; WR_BTN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            push(2, (k == N + 3) ? 8'h01 : 8'h00, $sformatf("wr_done_k%0d", k));
            if (k == 3) push(1, 8'h01, "busy_in_debounce");
        end
        WR_BTN = 1'b0;
        tick(4);
        push(1, 8'h00, "busy_after_release");
        push(3, 8'd1, "done_count_first");
        tick();
        PROG = 1'b0; CE = 1'b1; ADDR = 4'h5;
        push(0, 8'hA7, "read_5");
        tick();

        // Bounce: high 2 / low 1, five times -> never reaches WRITE
        PROG = 1'b1; CE = 1'b0; ADDR = 4'h2; D = 8'h55;
        for (int r = 0; r < 5; r++) begin
            WR_BTN = 1'b1; tick(2);
            WR_BTN = 1'b0; tick();
        end
        tick(4);
        push(3, 8'd1, "bounce_no_write");
        PROG = 1'b0; CE = 1'b1;
        push(0, init_mem[2], "bounce_mem2");
        tick();

        // Run mode: held button is ignored; CE=0 forces bus to zero
        PROG = 1'b0; CE = 1'b0; WR_BTN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ADDR = 4'(k);
            push(1, 8'h00, "run_busy");
            if (k == 5) push(0, 8'h00, "ce0_bus_5");
            if (k == 12) push(0, 8'h00, "ce0_bus_c");
            tick();
        end
        WR_BTN = 1'b0;
        tick(3);
        push(3, 8'd1, "run_no_write");
        tick();

        // PROG dropped during debounce aborts
        PROG = 1'b1; ADDR = 4'h7; D = 8'h3C; WR_BTN = 1'b1;
        tick(4);
        push(1, 8'h01, "abort_prog_busy");
        tick();
        PROG = 1'b0;
        tick();
        push(1, 8'h00, "abort_prog_idle");
        tick();
        WR_BTN = 1'b0;
        tick(3);
        push(3, 8'd1, "abort_prog_no_write");
        CE = 1'b1;
        push(0, init_mem[7], "abort_prog_mem7");
        tick();

        // CLR during debounce aborts and re-initialises memory
        PROG = 1'b1; CE = 1'b0; WR_BTN = 1'b1;
        tick(4);
        push(1, 8'h01, "abort_clr_busy");
        tick();
        CLR = 1'b1;
        #1;
        push(1, 8'h00, "abort_clr_idle");
        tick();
        WR_BTN = 1'b0; CLR = 1'b0;
        tick(6);
        push(3, 8'd1, "abort_clr_no_write");
        CE = 1'b1; ADDR = 4'h7;
        push(0, init_mem[7], "abort_clr_mem7");
        tick();
        ADDR = 4'h5;
        push(0, init_mem[5], "clr_reinit_mem5");
        tick();

        // Held button: one write only; changing D while held has no effect
        PROG = 1'b1; CE = 1'b0; ADDR = 4'h1; D = 8'h11; WR_BTN = 1'b1;
        tick(8);
        push(3, 8'd2, "held_first_write");
        D = 8'h22;
        tick(5);
        push(1, 8'h01, "held_release_busy");
        CE = 1'b1;
        push(0, 8'h11, "held_mem1_11");
        tick();
        WR_BTN = 1'b0;
        tick(4);
        push(1, 8'h00, "held_idle");
        // Re-press; the WRITE cycle still reads the old word
        WR_BTN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            push(0, (k <= N + 3) ? 8'h11 : 8'h22, $sformatf("rd_during_wr_k%0d", k));
        end
        WR_BTN = 1'b0;
        tick(4);
        push(3, 8'd3, "second_write_count");
        PROG = 1'b0; ADDR = 4'h1;
        push(0, 8'h22, "final_mem1_22");
        tick(2);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
